// File: rtl/c1_write_scheduler.sv
// Round-robin scheduler sharing the CCI-P c1 write channel among NUM_REQ requesters, with
// almfull/outstanding back-pressure, response accounting and a drain handshake.
module c1_write_scheduler #(
  parameter int unsigned NUM_REQ         = 2,
  parameter int unsigned ADDR_W          = 42,
  parameter int unsigned DATA_W          = 512,
  parameter int unsigned MAX_OUTSTANDING = 64,
  parameter int unsigned CNT_W           = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      c1tx_valid,
  output logic [ADDR_W-1:0]         c1tx_addr,
  output logic [DATA_W-1:0]         c1tx_data,
  input  logic                      c1tx_almfull,
  input  logic                      c1rx_rsp_valid,
  input  logic                      c1rx_rsp_format,
  input  logic [1:0]                c1rx_rsp_cl_num,
  input  logic                      drain_req,
  output logic                      drain_done,
  output logic [CNT_W-1:0]          outstanding,
  output logic                      err_underflow
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {StRun, StDrainWait, StDrainDone} state_e;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   rr_q, rr_d;
  logic               vld_q, vld_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;

  logic               can_issue;
  logic               accept;
  logic [NUM_REQ-1:0] grant;
  logic [PTR_W-1:0]   gidx;
  logic [2:0]         dec;
  logic [CNT_W:0]     total;

  // Grant is suppressed while reset is held so nothing is accepted and then lost.
  always_comb begin
    can_issue = !reset && (state_q == StRun) && !drain_req && !c1tx_almfull &&
                (({1'b0, cnt_q} + (CNT_W+1)'(vld_q)) < (CNT_W+1)'(MAX_OUTSTANDING));
    grant  = '0;
    gidx   = '0;
    accept = 1'b0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (can_issue && !accept && req_valid[j] && (j >= 32'(rr_q))) begin
        grant[j] = 1'b1;
        gidx     = PTR_W'(j);
        accept   = 1'b1;
      end
    end
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (can_issue && !accept && req_valid[j] && (j < 32'(rr_q))) begin
        grant[j] = 1'b1;
        gidx     = PTR_W'(j);
        accept   = 1'b1;
      end
    end
  end

  always_comb begin
    vld_d  = accept;
    addr_d = addr_q;
    data_d = data_q;
    rr_d   = rr_q;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (grant[j]) begin
        addr_d = req_addr[j*ADDR_W +: ADDR_W];
        data_d = req_data[j*DATA_W +: DATA_W];
      end
    end
    if (accept) begin
      rr_d = (gidx == PTR_W'(NUM_REQ - 1)) ? '0 : gidx + PTR_W'(1);
    end
  end

  // Issue and response net out in a single update; over-decrement saturates at zero.
  always_comb begin
    dec = 3'd0;
    if (c1rx_rsp_valid) begin
      dec = c1rx_rsp_format ? ({1'b0, c1rx_rsp_cl_num} + 3'd1) : 3'd1;
    end
    total = {1'b0, cnt_q} + (CNT_W+1)'(vld_q);
    err_d = err_q;
    if ((CNT_W+1)'(dec) > total) begin
      cnt_d = '0;
      err_d = 1'b1;
    end else begin
      cnt_d = CNT_W'(total - (CNT_W+1)'(dec));
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun:       if (drain_req) state_d = StDrainWait;
      StDrainWait: if ((cnt_q == '0) && !vld_q) state_d = StDrainDone;
      StDrainDone: state_d = StRun;
      default:     state_d = StRun;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StRun;
      rr_q    <= '0;
      vld_q   <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      vld_q   <= vld_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign req_ready     = grant;
  assign c1tx_valid    = vld_q;
  assign c1tx_addr     = addr_q;
  assign c1tx_data     = data_q;
  assign drain_done    = (state_q == StDrainDone);
  assign outstanding   = cnt_q;
  assign err_underflow = err_q;

endmodule

// File: tb/tb_c1_write_scheduler.sv
// Bench for c1_write_scheduler: directed scenarios plus random traffic, all outputs checked
// every cycle against a behavioural model of the scheduling rules.
module tb_c1_write_scheduler;

  localparam int NR   = 2;
  localparam int AW   = 42;
  localparam int DW   = 64;
  localparam int MAXO = 8;
  localparam int CW   = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [NR-1:0]    req_valid;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    req_ready;
  logic             c1tx_valid;
  logic [AW-1:0]    c1tx_addr;
  logic [DW-1:0]    c1tx_data;
  logic             c1tx_almfull;
  logic             c1rx_rsp_valid;
  logic             c1rx_rsp_format;
  logic [1:0]       c1rx_rsp_cl_num;
  logic             drain_req;
  logic             drain_done;
  logic [CW-1:0]    outstanding;
  logic             err_underflow;

  c1_write_scheduler #(
    .NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .MAX_OUTSTANDING(MAXO), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
    .req_data(req_data), .req_ready(req_ready), .c1tx_valid(c1tx_valid),
    .c1tx_addr(c1tx_addr), .c1tx_data(c1tx_data), .c1tx_almfull(c1tx_almfull),
    .c1rx_rsp_valid(c1rx_rsp_valid), .c1rx_rsp_format(c1rx_rsp_format),
    .c1rx_rsp_cl_num(c1rx_rsp_cl_num), .drain_req(drain_req), .drain_done(drain_done),
    .outstanding(outstanding), .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: 0 = issuing, 1 = waiting for drain, 2 = drain complete
  int            m_mode = 0;
  int            m_cnt  = 0;
  int            m_next = 0;
  bit            m_vld  = 0;
  bit            m_err  = 0;
  bit            m_ok   = 0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_data = '0;
  logic [NR-1:0] last_acc = '0;

  always @(negedge clk) begin
    logic [NR-1:0] exp_ready;
    bit            can;
    int            dec, tot, g;
    exp_ready = '0;
    g = -1;
    can = !reset && (m_mode == 0) && !drain_req && !c1tx_almfull && (m_cnt + int'(m_vld) < MAXO);
    if (can) begin
      for (int i = 0; i < NR; i++) begin
        int r;
        r = (m_next + i) % NR;
        if (g < 0 && req_valid[r]) g = r;
      end
      if (g >= 0) exp_ready[g] = 1'b1;
    end
    last_acc = req_valid & req_ready;
    if (m_ok) begin
      chk("req_ready", 64'(req_ready), 64'(exp_ready));
      chk("c1tx_valid", 64'(c1tx_valid), 64'(m_vld));
      chk("c1tx_addr", 64'(c1tx_addr), 64'(m_addr));
      chk("c1tx_data", 64'(c1tx_data), 64'(m_data));
      chk("drain_done", 64'(drain_done), 64'(m_mode == 2));
      chk("outstanding", 64'(outstanding), 64'(m_cnt));
      chk("err_underflow", 64'(err_underflow), 64'(m_err));
    end
    if (reset) begin
      m_mode = 0; m_cnt = 0; m_next = 0; m_vld = 0; m_err = 0;
      m_addr = '0; m_data = '0; m_ok = 1;
    end else begin
      case (m_mode)
        0: if (drain_req) m_mode = 1;
        1: if (m_cnt == 0 && !m_vld) m_mode = 2;
        default: m_mode = 0;
      endcase
      dec = !c1rx_rsp_valid ? 0 : (c1rx_rsp_format ? int'(c1rx_rsp_cl_num) + 1 : 1);
      tot = m_cnt + int'(m_vld);
      if (dec > tot) begin
        m_cnt = 0;
        m_err = 1;
      end else begin
        m_cnt = tot - dec;
      end
      m_vld = (g >= 0);
      if (g >= 0) begin
        m_addr = req_addr[g*AW +: AW];
        m_data = req_data[g*DW +: DW];
        m_next = (g + 1) % NR;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int r, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[r] = 1'b1;
    req_addr[r*AW +: AW] = a;
    req_data[r*DW +: DW] = d;
  endtask

  task automatic rsp(input bit v, input bit fmt, input logic [1:0] cl);
    c1rx_rsp_valid  = v;
    c1rx_rsp_format = fmt;
    c1rx_rsp_cl_num = cl;
  endtask

  // Stop requesting and retire every write with single responses.
  task automatic flush();
    int n;
    req_valid = '0;
    c1tx_almfull = 1'b0;
    drain_req = 1'b0;
    tick();
    tick();
    n = 0;
    while (m_cnt > 0 && n < 100) begin
      rsp(1'b1, 1'b0, 2'd0);
      tick();
      n++;
    end
    rsp(1'b0, 1'b0, 2'd0);
    chk("flush_done", 64'(outstanding), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int dd;
    logic [63:0] rnd;
    reset = 1'b1;
    req_valid = '0; req_addr = '0; req_data = '0;
    c1tx_almfull = 1'b0; drain_req = 1'b0;
    rsp(1'b0, 1'b0, 2'd0);
    tick(); tick();
    reset = 1'b0;
    chk("rst_c1tx_valid", 64'(c1tx_valid), 64'd0);
    chk("rst_outstanding", 64'(outstanding), 64'd0);
    chk("rst_err", 64'(err_underflow), 64'd0);
    chk("rst_drain_done", 64'(drain_done), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);

    // Single requester, address bumped per accept
    for (int k = 0; k < 3; k++) begin
      set_req(0, AW'(64'h100 + 64'(k)), 64'hD0D0_0000_0000_0000 + 64'(k));
      tick();
      chk("single_valid", 64'(c1tx_valid), 64'd1);
      chk("single_addr", 64'(c1tx_addr), 64'h100 + 64'(k));
    end
    req_valid = '0;
    tick();
    chk("single_out3", 64'(outstanding), 64'd3);
    chk("single_hold_addr", 64'(c1tx_addr), 64'h102);
    for (int k = 0; k < 3; k++) begin
      rsp(1'b1, 1'b0, 2'd0);
      tick();
    end
    rsp(1'b0, 1'b0, 2'd0);
    chk("single_out0", 64'(outstanding), 64'd0);

    // Fairness: pointer sits at requester 1 after the last requester-0 grant
    set_req(0, AW'(64'h200), 64'hAAAA);
    set_req(1, AW'(64'h300), 64'hBBBB);
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("fair_valid", 64'(c1tx_valid), 64'd1);
      chk("fair_addr", 64'(c1tx_addr), (k % 2 == 0) ? 64'h300 : 64'h200);
    end
    flush();

    // Back-pressure from almfull
    set_req(0, AW'(64'h400), 64'h1);
    set_req(1, AW'(64'h500), 64'h2);
    c1tx_almfull = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("almfull_no_issue", 64'(c1tx_valid), 64'd0);
    end
    c1tx_almfull = 1'b0;
    tick();
    chk("almfull_resume", 64'(c1tx_valid), 64'd1);
    flush();

    // Outstanding cap
    set_req(0, AW'(64'h600), 64'h3);
    for (int k = 0; k < 12; k++) tick();
    chk("cap_out", 64'(outstanding), 64'(MAXO));
    chk("cap_no_issue", 64'(c1tx_valid), 64'd0);
    rsp(1'b1, 1'b1, 2'd1);
    tick();
    rsp(1'b0, 1'b0, 2'd0);
    chk("cap_packed", 64'(outstanding), 64'(MAXO - 2));
    tick();
    chk("cap_resume", 64'(c1tx_valid), 64'd1);
    flush();

    // Drain with five writes in flight
    set_req(0, AW'(64'h700), 64'h4);
    for (int k = 0; k < 5; k++) tick();
    req_valid = '0;
    tick();
    chk("drain_out5", 64'(outstanding), 64'd5);
    set_req(1, AW'(64'h800), 64'h5);
    drain_req = 1'b1;
    tick();
    drain_req = 1'b0;
    rsp(1'b1, 1'b1, 2'd3);
    tick();
    rsp(1'b1, 1'b0, 2'd0);
    tick();
    rsp(1'b0, 1'b0, 2'd0);
    chk("drain_blocked", 64'(c1tx_valid), 64'd0);
    dd = 0;
    for (int n = 0; n < 8; n++) begin
      tick();
      if (drain_done) dd++;
      if (c1tx_valid) break;
    end
    chk("drain_done_once", 64'(dd), 64'd1);
    chk("drain_resume_valid", 64'(c1tx_valid), 64'd1);
    chk("drain_resume_addr", 64'(c1tx_addr), 64'h800);
    flush();

    // Underflow, then reset with writes in flight
    rsp(1'b1, 1'b0, 2'd0);
    tick();
    rsp(1'b0, 1'b0, 2'd0);
    chk("uflow_err", 64'(err_underflow), 64'd1);
    chk("uflow_out", 64'(outstanding), 64'd0);
    set_req(0, AW'(64'h900), 64'h6);
    for (int k = 0; k < 7; k++) tick();
    req_valid = '0;
    tick();
    chk("pre_reset_out7", 64'(outstanding), 64'd7);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("reset_out", 64'(outstanding), 64'd0);
    chk("reset_err", 64'(err_underflow), 64'd0);

    // Random traffic; requesters hold each request until it is accepted
    for (int c = 0; c < 600; c++) begin
      for (int r = 0; r < NR; r++) begin
        if (!req_valid[r] || last_acc[r]) begin
          if ($urandom_range(0, 3) != 0) begin
            rnd = {$urandom, $urandom};
            set_req(r, rnd[AW-1:0], {$urandom, $urandom});
          end else begin
            req_valid[r] = 1'b0;
          end
        end
      end
      c1tx_almfull = ($urandom_range(0, 7) == 0);
      drain_req = ($urandom_range(0, 29) == 0);
      if (m_cnt > 0 && $urandom_range(0, 1) == 0) begin
        if ($urandom_range(0, 1) == 0) rsp(1'b1, 1'b0, 2'($urandom_range(0, 3)));
        else rsp(1'b1, 1'b1, 2'($urandom_range(0, (m_cnt > 4) ? 3 : m_cnt - 1)));
      end else begin
        rsp(1'b0, 1'b0, 2'd0);
      end
      tick();
    end
    flush();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
